// File: rtl/fwd_hazard_if.sv
// fwd_hazard_if: operand/forwarding bundle between ID/EX and the ALU muxes.
// slave = fwd_hazard_unit; master = pipeline side driving stage fields.
interface fwd_hazard_if #(
  parameter int REG_WIDTH   = 64,
  parameter int ADDR_WIDTH  = 5,
  parameter int NUM_SRC     = 2,
  parameter int STALL_CNT_W = 32
);
  logic [NUM_SRC*ADDR_WIDTH-1:0] id_rs;
  logic [NUM_SRC-1:0]            id_rs_used;
  logic [ADDR_WIDTH-1:0]         id_ex_rd;
  logic                          id_ex_regwrite;
  logic                          id_ex_is_load;
  logic [NUM_SRC*ADDR_WIDTH-1:0] ex_rs;
  logic [NUM_SRC*REG_WIDTH-1:0]  ex_rs_data;
  logic [ADDR_WIDTH-1:0]         ex_mem_rd;
  logic                          ex_mem_regwrite;
  logic [REG_WIDTH-1:0]          ex_mem_data;
  logic [ADDR_WIDTH-1:0]         mem_wb_rd;
  logic                          mem_wb_regwrite;
  logic [REG_WIDTH-1:0]          mem_wb_data;
  logic                          flush;
  logic [NUM_SRC*REG_WIDTH-1:0]  ex_fwd_data;
  logic [NUM_SRC*2-1:0]          fwd_sel;
  logic                          stall;
  logic                          bubble;
  logic [STALL_CNT_W-1:0]        stall_count;

  modport master (
    output id_rs, id_rs_used, id_ex_rd, id_ex_regwrite,
    output id_ex_is_load, ex_rs, ex_rs_data,
    output ex_mem_rd, ex_mem_regwrite, ex_mem_data,
    output mem_wb_rd, mem_wb_regwrite, mem_wb_data, flush,
    input  ex_fwd_data, fwd_sel, stall, bubble, stall_count
  );

  modport slave (
    input  id_rs, id_rs_used, id_ex_rd, id_ex_regwrite,
    input  id_ex_is_load, ex_rs, ex_rs_data,
    input  ex_mem_rd, ex_mem_regwrite, ex_mem_data,
    input  mem_wb_rd, mem_wb_regwrite, mem_wb_data, flush,
    output ex_fwd_data, fwd_sel, stall, bubble, stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: per-slot operand forwarding (EX/MEM, MEM/WB, history)
// plus load-use stall FSM. Ports: clk, rst_n, bus (fwd_hazard_if.slave).
module fwd_hazard_unit #(
  parameter int REG_WIDTH   = 64,
  parameter int ADDR_WIDTH  = 5,
  parameter int NUM_SRC     = 2,
  parameter int LOAD_LAT    = 1,
  parameter int STALL_CNT_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  fwd_hazard_if.slave bus
);
  localparam int AW = ADDR_WIDTH;
  localparam int RW = REG_WIDTH;
  localparam int CW = 3;
  localparam bit MULTI = LOAD_LAT > 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   hist_valid;
  logic [AW-1:0]          hist_rd;
  logic [RW-1:0]          hist_data;
  logic [STALL_CNT_W-1:0] stall_count;
  logic                   hz, hit, stall;
  logic [AW-1:0]          rs;
  logic                   nz;

  always_comb begin
    bus.fwd_sel     = '0;
    bus.ex_fwd_data = '0;
    rs = '0;
    nz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs = bus.ex_rs[i*AW +: AW];
      nz = rs != '0;
      priority case (1'b1)
        nz && bus.ex_mem_regwrite && bus.ex_mem_rd == rs: begin
          bus.fwd_sel[i*2 +: 2]      = 2'b10;
          bus.ex_fwd_data[i*RW +: RW] = bus.ex_mem_data;
        end
        nz && bus.mem_wb_regwrite && bus.mem_wb_rd == rs: begin
          bus.fwd_sel[i*2 +: 2]      = 2'b01;
          bus.ex_fwd_data[i*RW +: RW] = bus.mem_wb_data;
        end
        nz && hist_valid && hist_rd == rs: begin
          bus.fwd_sel[i*2 +: 2]      = 2'b11;
          bus.ex_fwd_data[i*RW +: RW] = hist_data;
        end
        default: begin
          bus.fwd_sel[i*2 +: 2]      = 2'b00;
          bus.ex_fwd_data[i*RW +: RW] = bus.ex_rs_data[i*RW +: RW];
        end
      endcase
    end
  end

  // Covers the regfile's missing write-through; flush leaves it intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_valid <= 1'b0;
      hist_rd    <= '0;
      hist_data  <= '0;
    end else if (bus.mem_wb_regwrite && bus.mem_wb_rd != '0) begin
      hist_valid <= 1'b1;
      hist_rd    <= bus.mem_wb_rd;
      hist_data  <= bus.mem_wb_data;
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (bus.id_rs_used[i] && bus.id_rs[i*AW +: AW] == bus.id_ex_rd)
        hit = 1'b1;
    hz = bus.id_ex_regwrite & bus.id_ex_is_load &
         (bus.id_ex_rd != '0) & hit & ~bus.flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The first stall cycle happens in IDLE; WAIT covers the rest.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (hz && MULTI) begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (bus.flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      S_IDLE:  stall = hz;
      S_WAIT:  stall = ~bus.flush;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stall && stall_count != '1)
      stall_count <= stall_count + STALL_CNT_W'(1);
  end

  assign bus.stall       = stall;
  assign bus.bubble      = stall;
  assign bus.stall_count = stall_count;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed + random checks of fwd_hazard_unit.
// Two DUTs: LOAD_LAT=1 (32-bit count) and LOAD_LAT=3 (4-bit count).
module tb_fwd_hazard_unit;
  localparam int RW = 64;
  localparam int AW = 5;
  localparam int NS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NS*AW-1:0]  id_rs, ex_rs;
  logic [NS-1:0]     id_rs_used;
  logic [AW-1:0]     id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic              id_ex_regwrite, id_ex_is_load;
  logic              ex_mem_regwrite, mem_wb_regwrite, flush;
  logic [NS*RW-1:0]  ex_rs_data;
  logic [RW-1:0]     ex_mem_data, mem_wb_data;

  fwd_hazard_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .NUM_SRC(NS),
    .STALL_CNT_W(32)) b1 ();
  fwd_hazard_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .NUM_SRC(NS),
    .STALL_CNT_W(4)) b3 ();

  assign b1.id_rs = id_rs;
  assign b1.id_rs_used = id_rs_used;
  assign b1.id_ex_rd = id_ex_rd;
  assign b1.id_ex_regwrite = id_ex_regwrite;
  assign b1.id_ex_is_load = id_ex_is_load;
  assign b1.ex_rs = ex_rs;
  assign b1.ex_rs_data = ex_rs_data;
  assign b1.ex_mem_rd = ex_mem_rd;
  assign b1.ex_mem_regwrite = ex_mem_regwrite;
  assign b1.ex_mem_data = ex_mem_data;
  assign b1.mem_wb_rd = mem_wb_rd;
  assign b1.mem_wb_regwrite = mem_wb_regwrite;
  assign b1.mem_wb_data = mem_wb_data;
  assign b1.flush = flush;

  assign b3.id_rs = id_rs;
  assign b3.id_rs_used = id_rs_used;
  assign b3.id_ex_rd = id_ex_rd;
  assign b3.id_ex_regwrite = id_ex_regwrite;
  assign b3.id_ex_is_load = id_ex_is_load;
  assign b3.ex_rs = ex_rs;
  assign b3.ex_rs_data = ex_rs_data;
  assign b3.ex_mem_rd = ex_mem_rd;
  assign b3.ex_mem_regwrite = ex_mem_regwrite;
  assign b3.ex_mem_data = ex_mem_data;
  assign b3.mem_wb_rd = mem_wb_rd;
  assign b3.mem_wb_regwrite = mem_wb_regwrite;
  assign b3.mem_wb_data = mem_wb_data;
  assign b3.flush = flush;

  fwd_hazard_unit #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .NUM_SRC(NS),
    .LOAD_LAT(1), .STALL_CNT_W(32)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  fwd_hazard_unit #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .NUM_SRC(NS),
    .LOAD_LAT(3), .STALL_CNT_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3));

  // reference model state
  bit          hv;
  logic [AW-1:0] hrd;
  logic [RW-1:0] hdata;
  int          rem1, rem3;
  int unsigned cnt1, cnt3;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [1:0] m_sel(int i);
    logic [AW-1:0] r;
    r = ex_rs[i*AW +: AW];
    if (r == 0) return 2'b00;
    if (ex_mem_regwrite && ex_mem_rd == r) return 2'b10;
    if (mem_wb_regwrite && mem_wb_rd == r) return 2'b01;
    if (hv && hrd == r) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [RW-1:0] m_data(int i);
    case (m_sel(i))
      2'b10:   return ex_mem_data;
      2'b01:   return mem_wb_data;
      2'b11:   return hdata;
      default: return ex_rs_data[i*RW +: RW];
    endcase
  endfunction

  function automatic logic m_hz();
    logic h;
    h = 1'b0;
    for (int j = 0; j < NS; j++)
      if (id_rs_used[j] && id_rs[j*AW +: AW] == id_ex_rd) h = 1'b1;
    return id_ex_regwrite && id_ex_is_load && id_ex_rd != 0 &&
           h && !flush;
  endfunction

  // rem = stall cycles still owed by an accepted hazard
  function automatic logic m_stall(int rem);
    if (rem > 0) return !flush;
    return m_hz();
  endfunction

  task automatic model_reset();
    hv = 0; hrd = '0; hdata = '0;
    rem1 = 0; rem3 = 0; cnt1 = 0; cnt3 = 0;
  endtask

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    logic [2*NS-1:0] es;
    logic [NS*RW-1:0] ed;
    for (int i = 0; i < NS; i++) begin
      es[i*2 +: 2]   = m_sel(i);
      ed[i*RW +: RW] = m_data(i);
    end
    chk({tag, ":sel1"}, 128'(b1.fwd_sel), 128'(es));
    chk({tag, ":sel3"}, 128'(b3.fwd_sel), 128'(es));
    chk({tag, ":data1"}, 128'(b1.ex_fwd_data), 128'(ed));
    chk({tag, ":data3"}, 128'(b3.ex_fwd_data), 128'(ed));
    chk({tag, ":stall1"}, 128'(b1.stall), 128'(m_stall(rem1)));
    chk({tag, ":bubble1"}, 128'(b1.bubble), 128'(m_stall(rem1)));
    chk({tag, ":stall3"}, 128'(b3.stall), 128'(m_stall(rem3)));
    chk({tag, ":bubble3"}, 128'(b3.bubble), 128'(m_stall(rem3)));
    chk({tag, ":cnt1"}, 128'(b1.stall_count), 128'(cnt1));
    chk({tag, ":cnt3"}, 128'(b3.stall_count), 128'(cnt3));
  endtask

  task automatic tick();
    logic s1, s3, h;
    s1 = m_stall(rem1);
    s3 = m_stall(rem3);
    h  = m_hz();
    @(posedge clk);
    if (rst_n) begin
      if (rem1 > 0) rem1 = flush ? 0 : rem1 - 1;
      if (rem3 > 0) rem3 = flush ? 0 : rem3 - 1;
      else if (h) rem3 = 2;
      if (s1) cnt1++;
      if (s3 && cnt3 < 15) cnt3++;
      if (mem_wb_regwrite && mem_wb_rd != 0) begin
        hv = 1; hrd = mem_wb_rd; hdata = mem_wb_data;
      end
    end
    #1;
  endtask

  task automatic clear_in();
    id_rs = '0; id_rs_used = '0; id_ex_rd = '0;
    id_ex_regwrite = 0; id_ex_is_load = 0; ex_rs = '0;
    ex_mem_rd = '0; ex_mem_regwrite = 0; ex_mem_data = '0;
    mem_wb_rd = '0; mem_wb_regwrite = 0; mem_wb_data = '0;
    flush = 0;
  endtask

  task automatic load_hz();
    id_ex_rd = 5'd3; id_ex_regwrite = 1; id_ex_is_load = 1;
    id_rs[AW-1:0] = 5'd3; id_rs_used = 2'b01;
  endtask

  task automatic rand_in();
    for (int i = 0; i < NS; i++) begin
      id_rs[i*AW +: AW] = AW'($urandom_range(0, 7));
      ex_rs[i*AW +: AW] = AW'($urandom_range(0, 7));
      ex_rs_data[i*RW +: RW] = {$urandom, $urandom};
    end
    id_rs_used = NS'($urandom);
    id_ex_rd = AW'($urandom_range(0, 7));
    id_ex_regwrite = 1'($urandom);
    id_ex_is_load = 1'($urandom);
    ex_mem_rd = AW'($urandom_range(0, 7));
    ex_mem_regwrite = 1'($urandom);
    ex_mem_data = {$urandom, $urandom};
    mem_wb_rd = AW'($urandom_range(0, 7));
    mem_wb_regwrite = 1'($urandom);
    mem_wb_data = {$urandom, $urandom};
    flush = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    clear_in();
    ex_rs_data = {$urandom, $urandom, $urandom, $urandom};
    rst_n = 0;
    model_reset();
    #3;
    chk_all("rst");
    chk("rst_cnt3", 128'(b3.stall_count), 128'(0));
    chk("rst_stall1", 128'(b1.stall), 128'(0));
    #5 rst_n = 1;
    tick();

    // forward priority
    mem_wb_rd = 5'd5; mem_wb_data = 64'hCC; mem_wb_regwrite = 1;
    tick();
    clear_in();
    ex_rs[AW-1:0] = 5'd5;
    ex_mem_rd = 5'd5; ex_mem_data = 64'hAA; ex_mem_regwrite = 1;
    mem_wb_rd = 5'd5; mem_wb_data = 64'hBB; mem_wb_regwrite = 1;
    #2 chk_all("pri");
    chk("pri_exmem_sel", 128'(b1.fwd_sel[1:0]), 128'(2'b10));
    chk("pri_exmem_dat", 128'(b1.ex_fwd_data[RW-1:0]), 128'(64'hAA));
    ex_mem_regwrite = 0;
    #1 chk("pri_memwb_sel", 128'(b1.fwd_sel[1:0]), 128'(2'b01));
    chk("pri_memwb_dat", 128'(b1.ex_fwd_data[RW-1:0]), 128'(64'hBB));
    mem_wb_regwrite = 0;
    #1 chk("pri_hist_sel", 128'(b3.fwd_sel[1:0]), 128'(2'b11));
    chk("pri_hist_dat", 128'(b3.ex_fwd_data[RW-1:0]), 128'(64'hCC));

    // x0 guard
    clear_in();
    ex_mem_regwrite = 1; mem_wb_regwrite = 1;
    ex_mem_data = 64'h11; mem_wb_data = 64'h22;
    #1 chk("x0_sel", 128'(b1.fwd_sel), 128'(0));
    chk("x0_dat", 128'(b1.ex_fwd_data), 128'(ex_rs_data));
    chk_all("x0");
    tick();

    // history window
    clear_in();
    mem_wb_rd = 5'd7; mem_wb_data = 64'h1234; mem_wb_regwrite = 1;
    tick();
    clear_in();
    ex_rs[2*AW-1:AW] = 5'd7;
    #2 chk_all("hist");
    chk("hist_sel", 128'(b1.fwd_sel[3:2]), 128'(2'b11));
    chk("hist_dat", 128'(b1.ex_fwd_data[2*RW-1:RW]), 128'(64'h1234));
    mem_wb_rd = 5'd8; mem_wb_data = 64'h5678; mem_wb_regwrite = 1;
    tick();
    mem_wb_regwrite = 0;
    #2 chk("hist_over_sel", 128'(b1.fwd_sel[3:2]), 128'(2'b00));
    chk_all("hist_over");

    // load-use, both latencies
    clear_in();
    load_hz();
    #2 chk_all("lu0");
    chk("lu_s1_c0", 128'(b1.stall), 128'(1));
    chk("lu_s3_c0", 128'(b3.stall), 128'(1));
    tick();
    clear_in();
    #2 chk_all("lu1");
    chk("lu_s1_c1", 128'(b1.stall), 128'(0));
    chk("lu_s3_c1", 128'(b3.stall), 128'(1));
    tick();
    #2 chk("lu_s3_c2", 128'(b3.stall), 128'(1));
    tick();
    #2 chk("lu_s3_c3", 128'(b3.stall), 128'(0));
    chk("lu_cnt1", 128'(b1.stall_count), 128'(1));
    chk("lu_cnt3", 128'(b3.stall_count), 128'(3));
    chk_all("lu3");

    load_hz();
    id_rs_used = 2'b00;
    #1 chk("lu_unused1", 128'(b1.stall), 128'(0));
    chk("lu_unused3", 128'(b3.stall), 128'(0));
    tick();

    // flush in second stall cycle
    clear_in();
    load_hz();
    #2 chk_all("fl0");
    tick();
    clear_in();
    flush = 1;
    #2 chk("fl_s3", 128'(b3.stall), 128'(0));
    chk_all("fl1");
    tick();
    flush = 0;
    #2 chk("fl_idle_s3", 128'(b3.stall), 128'(0));
    chk("fl_cnt3", 128'(b3.stall_count), 128'(4));
    chk("fl_cnt1", 128'(b1.stall_count), 128'(2));
    chk_all("fl2");

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rand_in();
      #2 chk_all("rnd");
      tick();
    end

    // async reset mid-WAIT
    clear_in();
    repeat (4) tick();
    mem_wb_rd = 5'd9; mem_wb_data = 64'h99; mem_wb_regwrite = 1;
    tick();
    clear_in();
    load_hz();
    #2 chk_all("ar0");
    tick();
    clear_in();
    ex_rs[AW-1:0] = 5'd9;
    #2 chk("ar_wait_s3", 128'(b3.stall), 128'(1));
    chk("ar_hist_sel", 128'(b3.fwd_sel[1:0]), 128'(2'b11));
    rst_n = 0;
    model_reset();
    #1 chk("ar_s3", 128'(b3.stall), 128'(0));
    chk("ar_b3", 128'(b3.bubble), 128'(0));
    chk("ar_cnt3", 128'(b3.stall_count), 128'(0));
    chk("ar_cnt1", 128'(b1.stall_count), 128'(0));
    chk("ar_hv_sel", 128'(b3.fwd_sel[1:0]), 128'(2'b00));
    chk_all("ar");
    tick();
    #1 rst_n = 1;
    #1 chk_all("post_rst");
    tick();
    #2 chk_all("post_rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
